onchip_ram_pipelined: RTL

ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

---
 rtl/onchip_ram_pipelined.sv | 125 ++++++++++++
 1 files changed

// File: rtl/onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM with byte enables, a 1- or 2-stage read pipeline that stalls on clock enable,
// an optional zero-fill sweep after reset and a sticky out-of-range flag.
`timescale 1ns/1ps
module onchip_ram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 13,
    parameter int DEPTH          = 6250,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    reset_req,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done,
    output logic                    range_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {INIT_CLR, READY} state_t;

    localparam state_t LP_RST_STATE = (CLEAR_ON_RESET != 0) ? INIT_CLR : READY;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [ADDR_WIDTH-1:0]   r_clrCnt;
    logic                    r_initDone;
    logic                    r_rangeErr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    r_v1;
    logic                    r_v2;
    logic [DATA_WIDTH-1:0]   r_d1;
    logic [DATA_WIDTH-1:0]   r_d2;
    logic [DATA_WIDTH-1:0]   r_hold;

    logic                    w_en;
    logic                    w_accept;
    logic                    w_wrAcc;
    logic                    w_rdAcc;
    logic                    w_inRange;
    logic                    w_finV;
    logic [DATA_WIDTH-1:0]   w_finD;

    assign w_en      = clken & ~reset_req;
    assign w_inRange = ({1'b0, address} < LP_DEPTH);
    assign w_accept  = chipselect & (read | write) & ~waitrequest;
    assign w_wrAcc   = w_accept & write;
    assign w_rdAcc   = w_accept & read & ~write;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            INIT_CLR: if (r_clrCnt == LP_LAST) w_stateNext = READY;
            READY:    w_stateNext = READY;
            default:  w_stateNext = READY;
        endcase
    end

    // The sweep counter only runs in INIT_CLR; the enable inputs never pause it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LP_RST_STATE;
            r_clrCnt   <= '0;
            r_initDone <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_initDone <= (w_stateNext == READY);
            if (r_state == INIT_CLR) r_clrCnt <= r_clrCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && r_state == INIT_CLR) begin
            r_mem[r_clrCnt] <= '0;
        end else if (w_wrAcc && w_inRange) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byteenable[b]) r_mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    // Both stages advance together only on enabled cycles, so a stall freezes every in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_hold     <= '0;
            r_rangeErr <= 1'b0;
        end else begin
            if (w_en) begin
                r_v1 <= w_rdAcc;
                r_d1 <= w_inRange ? r_mem[address] : '0;
                r_v2 <= r_v1;
                r_d2 <= r_d1;
            end
            if (readdatavalid) r_hold <= w_finD;
            if ((w_wrAcc || w_rdAcc) && !w_inRange) r_rangeErr <= 1'b1;
        end
    end

    assign w_finV = (READ_LATENCY == 2) ? r_v2 : r_v1;
    assign w_finD = (READ_LATENCY == 2) ? r_d2 : r_d1;

    assign readdatavalid = w_finV & w_en & ~reset;
    assign readdata      = readdatavalid ? w_finD : r_hold;
    assign waitrequest   = ~r_initDone | ~w_en;
    assign init_done     = r_initDone;
    assign range_err     = r_rangeErr;

endmodule
